// File: rtl/pc_gen_unit.sv
// Fetch PC generator: BOOT/RUN/HALT sequencing, redirect priority, target legality trap.
// Optional performance counters are built only when PC_GEN_PERF_EN is defined.
module pc_gen_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(32'h0000_0000),
   parameter logic [DATA_WIDTH-1:0] PC_MAX = DATA_WIDTH'(32'h0000_0100),
   parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = DATA_WIDTH'(32'h0000_0080)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pc_ready,
   output logic                  pc_valid,
   output logic [DATA_WIDTH-1:0] pc_out,
   input  logic [DATA_WIDTH-1:0] ex_pc,
   input  logic [DATA_WIDTH-1:0] imm,
   input  logic [DATA_WIDTH-1:0] rs1_data,
   input  logic                  branch_en,
   input  logic                  jmp_en,
   input  logic                  jalr_en,
   input  logic                  flush_en,
   input  logic [DATA_WIDTH-1:0] flush_pc,
   input  logic                  halt_req,
   output logic                  halted,
   output logic                  fault,
   output logic [DATA_WIDTH-1:0] fault_addr,
   output logic [31:0]           redirect_cnt,
   output logic [31:0]           stall_cnt
);
   localparam int unsigned CNT_W = 32;
   localparam logic [DATA_WIDTH-1:0] SEQ_STEP = DATA_WIDTH'(4);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   state_t                state, state_next;
   logic [DATA_WIDTH-1:0] pc_next, fault_addr_next, target, jalr_sum;
   logic                  fault_next, redirect, check;

   assign jalr_sum = rs1_data + imm;

   // Next-state, redirect selection and target legality
   always_comb begin
      state_next      = state;
      pc_next         = pc_out;
      fault_next      = 1'b0;
      fault_addr_next = fault_addr;
      target          = pc_out + SEQ_STEP;
      check           = 1'b0;
      redirect        = 1'b0;

      unique case (state)
         BOOT:    state_next = RUN;
         RUN:     if (halt_req) state_next = HALT;
         HALT:    if (!halt_req) state_next = RUN;
         default: state_next = BOOT;
      endcase

      if (flush_en) begin
         pc_next  = flush_pc;
         redirect = 1'b1;
      end else if (jalr_en) begin
         target   = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
         check    = 1'b1;
         redirect = 1'b1;
      end else if (jmp_en || branch_en) begin
         target   = ex_pc + imm;
         check    = 1'b1;
         redirect = 1'b1;
      end else if (pc_valid && pc_ready) begin
         check    = 1'b1;
      end

      // Flush targets bypass this check; everything else traps when out of range or misaligned
      if (check) begin
         if ((target > PC_MAX) || (target[1:0] != 2'b00)) begin
            pc_next         = TRAP_VECTOR;
            fault_next      = 1'b1;
            fault_addr_next = target;
         end else begin
            pc_next = target;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BOOT;
         pc_out     <= RESET_VECTOR;
         pc_valid   <= 1'b0;
         halted     <= 1'b0;
         fault      <= 1'b0;
         fault_addr <= '0;
      end else begin
         state      <= state_next;
         pc_out     <= pc_next;
         pc_valid   <= (state_next == RUN);
         halted     <= (state_next == HALT);
         fault      <= fault_next;
         fault_addr <= fault_addr_next;
      end
   end

`ifdef PC_GEN_PERF_EN
   // Saturating redirect and fetch-stall counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_cnt <= '0;
         stall_cnt    <= '0;
      end else begin
         if (redirect && (redirect_cnt != '1)) redirect_cnt <= redirect_cnt + CNT_W'(1);
         if (pc_valid && !pc_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
`else
   assign redirect_cnt = '0;
   assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed self-checking bench for pc_gen_unit (default parameters).
// Counter expectations follow PC_GEN_PERF_EN when the bench is built with it.
module tb_pc_gen_unit;
`ifdef PC_GEN_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, pc_ready, pc_valid;
   logic [31:0] pc_out, ex_pc, imm, rs1_data, flush_pc, fault_addr;
   logic        branch_en, jmp_en, jalr_en, flush_en, halt_req, halted, fault;
   logic [31:0] redirect_cnt, stall_cnt;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   pc_gen_unit dut (
      .clk(clk), .rst_n(rst_n), .pc_ready(pc_ready), .pc_valid(pc_valid), .pc_out(pc_out),
      .ex_pc(ex_pc), .imm(imm), .rs1_data(rs1_data), .branch_en(branch_en), .jmp_en(jmp_en),
      .jalr_en(jalr_en), .flush_en(flush_en), .flush_pc(flush_pc), .halt_req(halt_req),
      .halted(halted), .fault(fault), .fault_addr(fault_addr),
      .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_redirects();
      branch_en = 1'b0; jmp_en = 1'b0; jalr_en = 1'b0; flush_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pc_ready = 1'b1; halt_req = 1'b0; clear_redirects();
      ex_pc = '0; imm = '0; rs1_data = '0; flush_pc = '0;
      #3;
      checks++; if (pc_out !== 32'h0 || pc_valid !== 1'b0 || halted !== 1'b0) begin
         failures++; $display("FAIL reset_pc got pc=%h valid=%b halted=%b exp pc=0 valid=0 halted=0", pc_out, pc_valid, halted); end
      checks++; if (fault !== 1'b0 || fault_addr !== 32'h0) begin
         failures++; $display("FAIL reset_fault got fault=%b addr=%h exp 0/0", fault, fault_addr); end
      checks++; if (redirect_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
         failures++; $display("FAIL reset_cnt got redir=%0d stall=%0d exp 0/0", redirect_cnt, stall_cnt); end
      @(negedge clk); rst_n = 1'b1; #1;
      checks++; if (pc_valid !== 1'b0 || pc_out !== 32'h0) begin
         failures++; $display("FAIL boot_cycle got valid=%b pc=%h exp valid=0 pc=0", pc_valid, pc_out); end
   endtask

   task automatic test_sequential();
      step();
      checks++; if (pc_valid !== 1'b1 || pc_out !== 32'h0) begin
         failures++; $display("FAIL seq_first got valid=%b pc=%h exp 1/0", pc_valid, pc_out); end
      step();
      checks++; if (pc_out !== 32'h4) begin failures++; $display("FAIL seq_4 got=%h exp=4", pc_out); end
      step();
      checks++; if (pc_out !== 32'h8) begin failures++; $display("FAIL seq_8 got=%h exp=8", pc_out); end
   endtask

   task automatic test_stall();
      step(); step();
      checks++; if (pc_out !== 32'h10) begin failures++; $display("FAIL stall_pre got=%h exp=10", pc_out); end
      pc_ready = 1'b0;
      for (int i = 0; i < 3; i++) step();
      checks++; if (pc_out !== 32'h10) begin failures++; $display("FAIL stall_hold got=%h exp=10", pc_out); end
      checks++; if (stall_cnt !== (PERF ? 32'd3 : 32'd0)) begin
         failures++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, PERF ? 3 : 0); end
      pc_ready = 1'b1;
   endtask

   task automatic test_priority();
      flush_en = 1'b1; flush_pc = 32'h40;
      jalr_en = 1'b1; rs1_data = 32'h21; imm = 32'h3;
      branch_en = 1'b1; ex_pc = 32'h0;
      step(); clear_redirects(); pc_ready = 1'b0;
      checks++; if (pc_out !== 32'h40 || fault !== 1'b0) begin
         failures++; $display("FAIL prio_flush got pc=%h fault=%b exp 40/0", pc_out, fault); end
      checks++; if (redirect_cnt !== (PERF ? 32'd1 : 32'd0)) begin
         failures++; $display("FAIL prio_redir_cnt got=%0d exp=%0d", redirect_cnt, PERF ? 1 : 0); end
   endtask

   task automatic test_jalr_branch();
      jalr_en = 1'b1; rs1_data = 32'h21; imm = 32'h3;
      step(); clear_redirects();
      checks++; if (pc_out !== 32'h24 || fault !== 1'b0) begin
         failures++; $display("FAIL jalr_target got pc=%h fault=%b exp 24/0", pc_out, fault); end
      branch_en = 1'b1; ex_pc = 32'hF0; imm = 32'h20;
      step(); clear_redirects();
      checks++; if (pc_out !== 32'h80 || fault !== 1'b1 || fault_addr !== 32'h110) begin
         failures++; $display("FAIL branch_trap got pc=%h fault=%b addr=%h exp 80/1/110", pc_out, fault, fault_addr); end
      step();
      checks++; if (fault !== 1'b0 || fault_addr !== 32'h110 || pc_out !== 32'h80) begin
         failures++; $display("FAIL fault_pulse got fault=%b addr=%h pc=%h exp 0/110/80", fault, fault_addr, pc_out); end
      jalr_en = 1'b1; rs1_data = 32'h10; imm = 32'h3;
      step(); clear_redirects();
      checks++; if (pc_out !== 32'h80 || fault !== 1'b1 || fault_addr !== 32'h12) begin
         failures++; $display("FAIL jalr_misalign got pc=%h fault=%b addr=%h exp 80/1/12", pc_out, fault, fault_addr); end
   endtask

   task automatic test_boundary();
      flush_en = 1'b1; flush_pc = 32'h203;
      step(); clear_redirects();
      checks++; if (pc_out !== 32'h203 || fault !== 1'b0) begin
         failures++; $display("FAIL flush_verbatim got pc=%h fault=%b exp 203/0", pc_out, fault); end
      flush_en = 1'b1; flush_pc = 32'hFC;
      step(); clear_redirects(); pc_ready = 1'b1;
      step();
      checks++; if (pc_out !== 32'h100 || fault !== 1'b0) begin
         failures++; $display("FAIL seq_pcmax got pc=%h fault=%b exp 100/0", pc_out, fault); end
      step(); pc_ready = 1'b0;
      checks++; if (pc_out !== 32'h80 || fault !== 1'b1 || fault_addr !== 32'h104) begin
         failures++; $display("FAIL seq_overflow got pc=%h fault=%b addr=%h exp 80/1/104", pc_out, fault, fault_addr); end
   endtask

   task automatic test_halt();
      flush_en = 1'b1; flush_pc = 32'h8;
      step(); clear_redirects();
      halt_req = 1'b1;
      step();
      checks++; if (halted !== 1'b1 || pc_valid !== 1'b0 || pc_out !== 32'h8) begin
         failures++; $display("FAIL halt_enter got halted=%b valid=%b pc=%h exp 1/0/8", halted, pc_valid, pc_out); end
      jmp_en = 1'b1; ex_pc = 32'h8; imm = 32'h10; pc_ready = 1'b1;
      step(); clear_redirects();
      checks++; if (halted !== 1'b1 || pc_valid !== 1'b0 || pc_out !== 32'h18) begin
         failures++; $display("FAIL halt_jmp got halted=%b valid=%b pc=%h exp 1/0/18", halted, pc_valid, pc_out); end
      step();
      checks++; if (pc_out !== 32'h18) begin failures++; $display("FAIL halt_hold got=%h exp=18", pc_out); end
      halt_req = 1'b0;
      step();
      checks++; if (halted !== 1'b0 || pc_valid !== 1'b1 || pc_out !== 32'h18) begin
         failures++; $display("FAIL halt_exit got halted=%b valid=%b pc=%h exp 0/1/18", halted, pc_valid, pc_out); end
      step();
      checks++; if (pc_out !== 32'h1C) begin failures++; $display("FAIL resume_seq got=%h exp=1c", pc_out); end
   endtask

   task automatic test_reset_mid();
      flush_en = 1'b1; flush_pc = 32'h30;
      step(); clear_redirects(); pc_ready = 1'b0;
      step(); step();
      #2;
      jmp_en = 1'b1; ex_pc = 32'h40; imm = 32'h4; rst_n = 1'b0;
      #1;
      checks++; if (pc_out !== 32'h0 || pc_valid !== 1'b0 || fault !== 1'b0) begin
         failures++; $display("FAIL async_reset got pc=%h valid=%b fault=%b exp 0/0/0", pc_out, pc_valid, fault); end
      checks++; if (redirect_cnt !== 32'h0 || stall_cnt !== 32'h0 || fault_addr !== 32'h0) begin
         failures++; $display("FAIL async_reset_cnt got redir=%0d stall=%0d addr=%h exp 0/0/0", redirect_cnt, stall_cnt, fault_addr); end
      step();
      checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_hold got=%h exp=0", pc_out); end
      clear_redirects(); pc_ready = 1'b1;
      @(negedge clk); rst_n = 1'b1;
      step();
      checks++; if (pc_valid !== 1'b1 || pc_out !== 32'h0) begin
         failures++; $display("FAIL post_reset_fetch got valid=%b pc=%h exp 1/0", pc_valid, pc_out); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_priority();
      test_jalr_branch();
      test_boundary();
      test_halt();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
